// File: rtl/surfboard_seq.sv
// surfboard_seq: sequential N x N matrix multiplier C = A x B built around a
// single time-multiplexed multiply-accumulate unit. Operands are captured on
// the input handshake; the result is held on c until the output handshake.
//
// Optional feature macro: SURFBOARD_SAT_EN
//   undefined : products truncated to W bits, W-bit accumulator wraps mod 2^W
//   defined   : full-precision accumulator (2W + clog2(N) bits), each result
//               element clamped to the W-bit signed/unsigned range
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for operands, in_ready high
// COMPUTE | one MAC per cycle over i/j/k, N^3 cycles, busy high
// DONE    | result presented on c with out_valid until out_ready
module surfboard_seq #(
    parameter int N      = 2,
    parameter int W      = 2,
    parameter int SIGNED = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*N*W-1:0] a,
    input  logic [N*N*W-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*N*W-1:0] c,
    output logic             busy
);

    localparam int CW = $clog2(N);
`ifdef SURFBOARD_SAT_EN
    localparam int AW = 2*W + $clog2(N);
    localparam logic [AW-1:0] SMAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic [AW-1:0] SMIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic [AW-1:0] UMAX = {{(AW-W){1'b0}}, {W{1'b1}}};
`else
    localparam int AW = W;
`endif

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t            state, state_nx;
    logic [N*N*W-1:0]  a_q, b_q;
    logic [AW-1:0]     acc, acc_nx, a_x, b_x;
    logic [W-1:0]      a_el, b_el, res;
    logic [CW-1:0]     i, j, k;
    logic              k_last, j_last, i_last;

    assign k_last    = (k == CW'(N-1));
    assign j_last    = (j == CW'(N-1));
    assign i_last    = (i == CW'(N-1));
    assign in_ready  = (state == IDLE);
    assign busy      = (state == COMPUTE);
    assign out_valid = (state == DONE);

    // MAC datapath: select A[i][k], B[k][j], extend to accumulator width, accumulate, clamp/truncate
    always_comb begin
        a_el = a_q[(int'(i)*N + int'(k))*W +: W];
        b_el = b_q[(int'(k)*N + int'(j))*W +: W];
        if (SIGNED != 0) begin
            a_x = AW'($signed(a_el));
            b_x = AW'($signed(b_el));
        end else begin
            a_x = AW'(a_el);
            b_x = AW'(b_el);
        end
        acc_nx = acc + a_x * b_x;
        res    = acc_nx[W-1:0];
`ifdef SURFBOARD_SAT_EN
        if (SIGNED != 0) begin
            if ($signed(acc_nx) > $signed(SMAX))
                res = {1'b0, {(W-1){1'b1}}};
            else if ($signed(acc_nx) < $signed(SMIN))
                res = {1'b1, {(W-1){1'b0}}};
        end else if (acc_nx > UMAX) begin
            res = '1;
        end
`endif
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)                  state_nx = COMPUTE;
            COMPUTE: if (k_last && j_last && i_last) state_nx = DONE;
            DONE:    if (out_ready)                 state_nx = IDLE;
            default:                                state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Operand capture, loop counters, accumulator and result writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            acc <= '0;
            i   <= '0;
            j   <= '0;
            k   <= '0;
            c   <= '0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                a_q <= a;
                b_q <= b;
                acc <= '0;
                i   <= '0;
                j   <= '0;
                k   <= '0;
            end
        end else if (state == COMPUTE) begin
            if (k_last) begin
                c[(int'(i)*N + int'(j))*W +: W] <= res;
                acc <= '0;
                k   <= '0;
                if (j_last) begin
                    j <= '0;
                    i <= i_last ? '0 : i + CW'(1);
                end else begin
                    j <= j + CW'(1);
                end
            end else begin
                acc <= acc_nx;
                k   <= k + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_surfboard_seq.sv
// Bench for surfboard_seq: three configurations side by side, directed and
// random transactions checked against an integer matrix-product model.
module tb_surfboard_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  iv, orr, ir, ov, bz;
    logic [71:0] abus, bbus;
    logic [7:0]  c0;
    logic [15:0] c1;
    logic [71:0] c2;

    int checks = 0;
    int errors = 0;
    int cfg_n[3] = '{2, 2, 3};
    int cfg_w[3] = '{2, 4, 8};
    int cfg_s[3] = '{1, 0, 1};
    int ma[3][3];
    int mb[3][3];

    surfboard_seq #(.N(2), .W(2), .SIGNED(1)) d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(abus[7:0]), .b(bbus[7:0]), .out_valid(ov[0]), .out_ready(orr[0]),
        .c(c0), .busy(bz[0]));
    surfboard_seq #(.N(2), .W(4), .SIGNED(0)) d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(abus[15:0]), .b(bbus[15:0]), .out_valid(ov[1]), .out_ready(orr[1]),
        .c(c1), .busy(bz[1]));
    surfboard_seq #(.N(3), .W(8), .SIGNED(1)) d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(abus), .b(bbus), .out_valid(ov[2]), .out_ready(orr[2]),
        .c(c2), .busy(bz[2]));

    task automatic chkv(string tag, logic [71:0] obs, logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] getc(int s);
        case (s)
            0:       return {64'b0, c0};
            1:       return {56'b0, c1};
            default: return c2;
        endcase
    endfunction

    function automatic logic [71:0] junk();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[71:0];
    endfunction

    function automatic logic [71:0] pack_m(int s, int m[3][3]);
        logic [71:0] v;
        int n, w, e;
        v = '0;
        n = cfg_n[s];
        w = cfg_w[s];
        for (int r = 0; r < n; r++)
            for (int q = 0; q < n; q++) begin
                e = m[r][q];
                for (int t = 0; t < w; t++) v[(r*n+q)*w+t] = e[t];
            end
        return v;
    endfunction

    // Plain matrix product; wrap comes from packing the low W bits.
    function automatic logic [71:0] expected(int s);
        int r[3][3];
        int n, w, sum;
        n = cfg_n[s];
        w = cfg_w[s];
        for (int x = 0; x < 3; x++)
            for (int y = 0; y < 3; y++) r[x][y] = 0;
        for (int x = 0; x < n; x++)
            for (int y = 0; y < n; y++) begin
                sum = 0;
                for (int z = 0; z < n; z++) sum += ma[x][z] * mb[z][y];
`ifdef SURFBOARD_SAT_EN
                if (cfg_s[s] != 0) begin
                    if (sum > (2**(w-1)) - 1) sum = (2**(w-1)) - 1;
                    if (sum < -(2**(w-1)))    sum = -(2**(w-1));
                end else begin
                    if (sum > (2**w) - 1)     sum = (2**w) - 1;
                end
`endif
                r[x][y] = sum;
            end
        return pack_m(s, r);
    endfunction

    task automatic rnd(int s);
        int w;
        w = cfg_w[s];
        for (int x = 0; x < 3; x++)
            for (int y = 0; y < 3; y++) begin
                if (cfg_s[s] != 0) begin
                    ma[x][y] = int'($urandom_range(0, (2**w)-1)) - 2**(w-1);
                    mb[x][y] = int'($urandom_range(0, (2**w)-1)) - 2**(w-1);
                end else begin
                    ma[x][y] = int'($urandom_range(0, (2**w)-1));
                    mb[x][y] = int'($urandom_range(0, (2**w)-1));
                end
            end
    endtask

    // Called right after E0 (+1): counts edges until out_valid, bounded.
    task automatic wait_ov(int s, output int edges, output int nbusy, output bit irbad);
        edges = 0;
        nbusy = 0;
        irbad = 0;
        while (ov[s] !== 1'b1 && edges < 200) begin
            if (bz[s] === 1'b1) nbusy++;
            if (ir[s] !== 1'b0) irbad = 1;
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic run_txn(int s, int stall);
        logic [71:0] exp;
        int n3, edges, nbusy;
        bit irbad, stbad;
        n3 = cfg_n[s] ** 3;
        exp = expected(s);
        abus = pack_m(s, ma);
        bbus = pack_m(s, mb);
        chk1("idle_in_ready", ir[s], 1'b1);
        iv[s] = 1'b1;
        @(posedge clk); #1;
        iv[s] = 1'b0;
        abus = junk();
        bbus = junk();
        wait_ov(s, edges, nbusy, irbad);
        chki("latency", edges, n3);
        chki("busy_cycles", nbusy, n3);
        chk1("in_ready_low_compute", irbad, 1'b0);
        chkv("result", getc(s), exp);
        chk1("busy_low_done", bz[s], 1'b0);
        stbad = 0;
        for (int t = 0; t < stall; t++) begin
            if (t == 2) begin iv[s] = 1'b1; abus = junk(); end
            if (t == 3) iv[s] = 1'b0;
            @(posedge clk); #1;
            if (ov[s] !== 1'b1 || getc(s) !== exp) stbad = 1;
        end
        iv[s] = 1'b0;
        chk1("stall_stable", stbad, 1'b0);
        orr[s] = 1'b1;
        @(posedge clk); #1;
        orr[s] = 1'b0;
        chk1("out_valid_fall", ov[s], 1'b0);
        chk1("in_ready_after", ir[s], 1'b1);
        chkv("c_kept", getc(s), exp);
    endtask

    initial begin
        logic [71:0] e1, e2;
        int edges, nbusy;
        bit irbad, ovseen;

        rst_n = 1'b0;
        iv = '0;
        orr = '0;
        abus = '0;
        bbus = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            chk1("rst_in_ready", ir[s], 1'b1);
            chk1("rst_out_valid", ov[s], 1'b0);
            chk1("rst_busy", bz[s], 1'b0);
            chkv("rst_c", getc(s), 72'b0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        ma = '{'{1, -1, 0}, '{0, 1, 0}, '{0, 0, 0}};
        mb = '{'{1, 1, 0}, '{-2, 1, 0}, '{0, 0, 0}};
        run_txn(0, 10);
        ma = '{'{3, 5, 0}, '{7, 2, 0}, '{0, 0, 0}};
        mb = '{'{4, 1, 0}, '{6, 9, 0}, '{0, 0, 0}};
        run_txn(1, 0);
        ma = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};
        mb = '{'{1, 2, 3}, '{4, 5, 6}, '{-7, -8, -9}};
        run_txn(2, 10);

        // Random transactions on every configuration
        for (int r = 0; r < 4; r++)
            for (int s = 0; s < 3; s++) begin
                rnd(s);
                run_txn(s, int'($urandom_range(0, 5)));
            end

        // Reset in the middle of COMPUTE
        rnd(0);
        abus = pack_m(0, ma);
        bbus = pack_m(0, mb);
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("midrst_busy", bz[0], 1'b0);
        chk1("midrst_out_valid", ov[0], 1'b0);
        chk1("midrst_in_ready", ir[0], 1'b1);
        chkv("midrst_c", getc(0), 72'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ovseen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ov[0] !== 1'b0) ovseen = 1;
        end
        chk1("midrst_no_out_valid", ovseen, 1'b0);
        rnd(0);
        run_txn(0, 0);

        // Back-to-back with in_valid held and out_ready high
        rnd(2);
        e1 = expected(2);
        abus = pack_m(2, ma);
        bbus = pack_m(2, mb);
        iv[2] = 1'b1;
        orr[2] = 1'b1;
        @(posedge clk); #1;
        rnd(2);
        e2 = expected(2);
        abus = pack_m(2, ma);
        bbus = pack_m(2, mb);
        wait_ov(2, edges, nbusy, irbad);
        chki("b2b_latency1", edges, 27);
        chkv("b2b_result1", getc(2), e1);
        @(posedge clk); #1;
        chk1("b2b_idle_out_valid", ov[2], 1'b0);
        chk1("b2b_idle_in_ready", ir[2], 1'b1);
        @(posedge clk); #1;
        chk1("b2b_second_accept", bz[2], 1'b1);
        iv[2] = 1'b0;
        wait_ov(2, edges, nbusy, irbad);
        chki("b2b_latency2", edges, 27);
        chkv("b2b_result2", getc(2), e2);
        @(posedge clk); #1;
        chk1("b2b_drain", ov[2], 1'b0);
        orr[2] = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/surfboard_seq.md
Name: surfboard_seq

Overview:
- Sequential, parametrised successor to the combinational 2x2 surfboard matrix multiplier.
- Computes C = A x B for N x N matrices of W-bit elements, signed or unsigned.
- Uses one time-multiplexed multiply-accumulate unit, with valid/ready handshakes on the input and output sides.
- Sits between an operand producer and a result consumer in the surfboard datapath.

Parameters:
- N, 2, matrix dimension (N >= 2).
- W, 2, element width in bits (W >= 2).
- SIGNED, 1, 1 = two's-complement operands/results, 0 = unsigned.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand matrices a/b valid.
- in_ready  output  1  block can accept operands.
- a  input  N*N*W  matrix A, row-major; element (i,j) at bits (i*N+j)*W +: W.
- b  input  N*N*W  matrix B, same packing.
- out_valid  output  1  result matrix c valid.
- out_ready  input  1  consumer accepts result.
- c  output  N*N*W  result matrix, same packing.
- busy  output  1  high while in COMPUTE.

Behaviour:
- Clocking and reset
  - Single clock domain.
  - rst_n is asynchronous active-low; it clears all state immediately on assertion.
- Reset values
  - state = IDLE, out_valid = 0, busy = 0, c = 0.
  - Internal A/B registers, accumulator and counters i/j/k = 0.
  - in_ready = 1 (decoded from IDLE).
- FSM states: IDLE, COMPUTE, DONE.
- IDLE
  - in_ready = 1.
  - On in_valid & in_ready at rising edge E0: register a and b, clear i/j/k and the accumulator, go to COMPUTE.
- COMPUTE
  - in_ready = 0, busy = 1.
  - Each edge: acc_next = acc + A[i][k]*B[k][j].
  - When k == N-1: write acc_next to C[i][j], clear acc, k = 0, then advance j. When j wraps, advance i.
  - Otherwise: k += 1.
  - Exactly N^3 edges (E1..E_{N^3}) are spent in COMPUTE.
  - At E_{N^3} (i = j = k = N-1) the last element is written and state goes to DONE.
- DONE
  - out_valid = 1, c stable.
  - out_valid and c are held indefinitely while out_ready = 0.
  - On out_valid & out_ready: go to IDLE, out_valid falls; c keeps its last value.
- Latency and throughput
  - out_valid first high in the cycle after E_{N^3}.
  - Throughput: one matrix per N^3 + 2 cycles minimum (no overlap of accept and drain).
- Operand handling
  - in_valid is ignored outside IDLE.
  - a/b are sampled only at E0; later changes have no effect.
- Arithmetic (default)
  - Each product is truncated to W bits; the accumulator is W bits and wraps modulo 2^W.
  - The result is bit-identical to the combinational surfboard for N = 2.
  - SIGNED selects signed vs unsigned multiply; for truncated results this only matters under the saturation feature.
- Reset mid-operation
  - rst_n low in any state aborts the operation and returns to reset values.
  - No partial result is presented.
- N = 2 latency: E1..E8, out_valid visible after the 8th edge.

Optional Feature:
- Macro: SURFBOARD_SAT_EN.
- Defined
  - Accumulator is full precision: 2W + clog2(N) bits, signed or unsigned per SIGNED; products are not truncated.
  - On each C[i][j] write, the sum is clamped:
    - Signed range: [-2^(W-1), 2^(W-1)-1].
    - Unsigned range: [0, 2^W-1].
  - Latency is unchanged.
- Undefined: wrap-around arithmetic as above.

Test Plan:
- N=2, W=2, SIGNED=1, A=[[1,-1],[0,1]], B=[[1,1],[-2,1]]
  - Default -> c = [[-1,0],[-2,1]] (C00 wraps 3 -> 2'b11).
  - With SURFBOARD_SAT_EN -> c = [[1,0],[-2,1]].
  - out_valid exactly 8 edges after accept.
- N=2, W=4, SIGNED=0, A=[[3,5],[7,2]], B=[[4,1],[6,9]]
  - Default -> c = [[10,0],[8,9]].
  - SAT_EN -> c = [[15,15],[15,15]].
- N=3, W=8, SIGNED=1, A = identity, B = [[1,2,3],[4,5,6],[-7,-8,-9]]
  - c = B.
  - busy high for exactly 27 cycles; in_ready = 0 throughout.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid.
  - c and out_valid stay stable.
  - in_valid pulses during the stall are not accepted.
  - Single out_ready cycle -> IDLE, in_ready = 1 the next cycle.
- Reset mid-COMPUTE: assert rst_n = 0 asynchronously at MAC 4 of 8.
  - Outputs go to reset values immediately, out_valid never pulses.
  - A fresh transaction after release produces the correct result.
- Back-to-back: two transactions with in_valid held high and out_ready = 1.
  - Second accepted on the first IDLE cycle after the first result handshake.
  - Both results correct.
